// File: rtl/pp_group_accumulator_if.sv
// pp_group_accumulator_if
//   Beat input and group-result output bundle for pp_group_accumulator.
//   master : producer/observer side (drives i_*, reads o_*)
//   slave  : the accumulator (reads i_*, drives o_*)
//   i_valid/i_pp/i_max_exp/i_Q_frac/i_last : one aligned beat
//   o_valid/o_sum/o_max_exp/o_Q_frac/o_exp_err : completed group result
interface pp_group_accumulator_if #(
  parameter int N_LANES = 8,
  parameter int PP_W    = 15,
  parameter int ACC_W   = 22
);
  logic                     i_valid;
  logic [N_LANES*PP_W-1:0]  i_pp;
  logic [5:0]               i_max_exp;
  logic [4:0]               i_Q_frac;
  logic                     i_last;
  logic                     o_valid;
  logic [ACC_W-1:0]         o_sum;
  logic [5:0]               o_max_exp;
  logic [4:0]               o_Q_frac;
  logic                     o_exp_err;

  modport master (
    output i_valid, i_pp, i_max_exp, i_Q_frac, i_last,
    input  o_valid, o_sum, o_max_exp, o_Q_frac, o_exp_err
  );
  modport slave (
    input  i_valid, i_pp, i_max_exp, i_Q_frac, i_last,
    output o_valid, o_sum, o_max_exp, o_Q_frac, o_exp_err
  );
endinterface

// File: rtl/pp_group_accumulator.sv
// pp_group_accumulator
//   Reduces N_LANES aligned signed partial products per beat through a
//   2-stage adder tree and accumulates vector sums over a group of beats
//   closed by i_last. Emits the group total with the first beat's max
//   exponent and Q fraction, plus a flag if any beat's exponent differed.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : pp_group_accumulator_if.slave (beat in, group result out)

// Sign-extends one lane pair to ACC_W and adds it.
module pp_pair_add #(
  parameter int PP_W  = 15,
  parameter int ACC_W = 22
) (
  input  logic [PP_W-1:0]  a,
  input  logic [PP_W-1:0]  b,
  output logic [ACC_W-1:0] sum
);
  assign sum = {{(ACC_W-PP_W){a[PP_W-1]}}, a} + {{(ACC_W-PP_W){b[PP_W-1]}}, b};
endmodule

module pp_group_accumulator #(
  parameter int N_LANES = 8,
  parameter int PP_W    = 15,
  parameter int GRP_W   = 4,
  parameter int ACC_W   = PP_W + $clog2(N_LANES) + GRP_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  pp_group_accumulator_if.slave  bus
);
  localparam int PAIRS = N_LANES / 2;

  typedef struct packed {
    logic       last;
    logic [5:0] max_exp;
    logic [4:0] q_frac;
  } meta_t;

  logic [N_LANES-1:0][PP_W-1:0] lane;
  logic [PAIRS-1:0][ACC_W-1:0]  ps_sum, ps_d, ps_q;
  meta_t                        meta_d, meta_q;
  // vld_pipe[0]: beat in stage 1; vld_pipe[1]: group completed (o_valid)
  logic [1:0]                   vld_pipe_d, vld_pipe_q;

  logic [ACC_W-1:0] vs;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic [5:0]       grp_exp_d, grp_exp_q;
  logic [4:0]       grp_q_d, grp_q_q;
  logic             err_d, err_q;
  logic             open_d, open_q;
  logic [ACC_W-1:0] o_sum_d, o_sum_q;
  logic [5:0]       o_exp_d, o_exp_q;
  logic [4:0]       o_q_d, o_q_q;
  logic             o_err_d, o_err_q;

  assign lane = bus.i_pp;

  // Stage 1: first tree level, one adder per lane pair
  for (genvar k = 0; k < PAIRS; k++) begin : g_pair
    pp_pair_add #(.PP_W(PP_W), .ACC_W(ACC_W)) u_pair (
      .a   (lane[2*k]),
      .b   (lane[2*k+1]),
      .sum (ps_sum[k])
    );
  end

  always_comb begin
    ps_d          = ps_q;
    meta_d        = meta_q;
    vld_pipe_d[0] = bus.i_valid;
    // data only moves on valid beats; idle-cycle inputs never reach stage 2
    if (bus.i_valid) begin
      ps_d   = ps_sum;
      meta_d = '{last: bus.i_last, max_exp: bus.i_max_exp, q_frac: bus.i_Q_frac};
    end
  end

  // Stage 2: rest of the tree plus group accumulation
  always_comb begin
    vs = '0;
    for (int k = 0; k < PAIRS; k++) vs = vs + ps_q[k];

    acc_d     = acc_q;
    grp_exp_d = grp_exp_q;
    grp_q_d   = grp_q_q;
    err_d     = err_q;
    open_d    = open_q;
    if (vld_pipe_q[0]) begin
      if (!open_q) begin
        // first beat overwrites so no stale sum leaks into the new group
        acc_d     = vs;
        grp_exp_d = meta_q.max_exp;
        grp_q_d   = meta_q.q_frac;
        err_d     = 1'b0;
      end else begin
        acc_d = acc_q + vs;
        err_d = err_q | (meta_q.max_exp != grp_exp_q);
      end
      open_d = ~meta_q.last;
    end

    vld_pipe_d[1] = vld_pipe_q[0] & meta_q.last;
    // outputs take the post-update values so the last beat is included
    o_sum_d = o_sum_q;
    o_exp_d = o_exp_q;
    o_q_d   = o_q_q;
    o_err_d = o_err_q;
    if (vld_pipe_d[1]) begin
      o_sum_d = acc_d;
      o_exp_d = grp_exp_d;
      o_q_d   = grp_q_d;
      o_err_d = err_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ps_q       <= '0;
      meta_q     <= '0;
      vld_pipe_q <= '0;
      acc_q      <= '0;
      grp_exp_q  <= '0;
      grp_q_q    <= '0;
      err_q      <= 1'b0;
      open_q     <= 1'b0;
      o_sum_q    <= '0;
      o_exp_q    <= '0;
      o_q_q      <= '0;
      o_err_q    <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      meta_q     <= meta_d;
      vld_pipe_q <= vld_pipe_d;
      acc_q      <= acc_d;
      grp_exp_q  <= grp_exp_d;
      grp_q_q    <= grp_q_d;
      err_q      <= err_d;
      open_q     <= open_d;
      o_sum_q    <= o_sum_d;
      o_exp_q    <= o_exp_d;
      o_q_q      <= o_q_d;
      o_err_q    <= o_err_d;
    end
  end

  assign bus.o_valid   = vld_pipe_q[1];
  assign bus.o_sum     = o_sum_q;
  assign bus.o_max_exp = o_exp_q;
  assign bus.o_Q_frac  = o_q_q;
  assign bus.o_exp_err = o_err_q;
endmodule

// File: tb/tb_pp_group_accumulator.sv
// tb_pp_group_accumulator
//   Directed beats with hand-computed group results; a scoreboard queue
//   holds expected results and a negedge monitor pops and compares them,
//   including the cycle at which o_valid must appear.
module tb_pp_group_accumulator;
  localparam int NL = 8, PW = 15, AW = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [AW-1:0] sum;
    logic [5:0]    e;
    logic [4:0]    q;
    logic          err;
    int            at;
  } exp_t;
  exp_t sb[$];

  pp_group_accumulator_if #(.N_LANES(NL), .PP_W(PW), .ACC_W(AW)) bus ();

  pp_group_accumulator #(.N_LANES(NL), .PP_W(PW), .GRP_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every o_valid must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.o_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_o_valid", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("o_valid_cycle", cyc,                 x.at);
        chk("o_sum",         {10'd0, bus.o_sum},  {10'd0, x.sum});
        chk("o_max_exp",     {26'd0, bus.o_max_exp}, {26'd0, x.e});
        chk("o_Q_frac",      {27'd0, bus.o_Q_frac},  {27'd0, x.q});
        chk("o_exp_err",     {31'd0, bus.o_exp_err}, {31'd0, x.err});
      end
    end
  end

  function automatic logic [NL-1:0][PW-1:0] vec(input int s);
    logic [NL-1:0][PW-1:0] v;
    v = '0;
    v[0] = PW'(s);
    return v;
  endfunction

  task automatic beat(input logic [NL-1:0][PW-1:0] l, input logic [5:0] e,
                      input logic [4:0] q, input logic last);
    @(negedge clk);
    bus.i_valid   = 1'b1;
    bus.i_pp      = l;
    bus.i_max_exp = e;
    bus.i_Q_frac  = q;
    bus.i_last    = last;
  endtask

  // Idle cycle with junk data and last=1: all of it must be ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_valid   = 1'b0;
      bus.i_pp      = {$urandom, $urandom, $urandom, $urandom};
      bus.i_max_exp = 6'($urandom);
      bus.i_Q_frac  = 5'($urandom);
      bus.i_last    = 1'b1;
    end
  endtask

  // Called right after driving a last beat: result due 2 cycles on
  task automatic expect_grp(input int s, input logic [5:0] e, input logic [4:0] q, input logic err);
    exp_t x;
    x.sum = AW'(s);
    x.e   = e;
    x.q   = q;
    x.err = err;
    x.at  = cyc + 2;
    sb.push_back(x);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_o_valid"},   {31'd0, bus.o_valid},   32'd0);
    chk({tag, "_o_sum"},     {10'd0, bus.o_sum},     32'd0);
    chk({tag, "_o_max_exp"}, {26'd0, bus.o_max_exp}, 32'd0);
    chk({tag, "_o_Q_frac"},  {27'd0, bus.o_Q_frac},  32'd0);
    chk({tag, "_o_exp_err"}, {31'd0, bus.o_exp_err}, 32'd0);
  endtask

  initial begin
    logic [NL-1:0][PW-1:0] l;
    bus.i_valid = 1'b0; bus.i_pp = '0; bus.i_max_exp = '0;
    bus.i_Q_frac = '0; bus.i_last = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // one-beat group, lanes 1..8
    for (int k = 0; k < NL; k++) l[k] = PW'(k + 1);
    beat(l, 6'd20, 5'd3, 1'b1); expect_grp(36, 6'd20, 5'd3, 1'b0);
    idle(3);

    // all lanes -1
    for (int k = 0; k < NL; k++) l[k] = 15'h7FFF;
    beat(l, 6'd5, 5'd1, 1'b1); expect_grp(-8, 6'd5, 5'd1, 1'b0);
    idle(3);

    // three beats with gaps: 100, -40, 5; 100 split across lanes
    l = '0; l[1] = 15'd60; l[6] = 15'd40;
    beat(l, 6'd7, 5'd2, 1'b0);
    idle(2);
    beat(vec(-40), 6'd7, 5'd9, 1'b0);
    beat(vec(5), 6'd7, 5'd9, 1'b1); expect_grp(65, 6'd7, 5'd2, 1'b0);
    idle(3);

    // back-to-back groups
    beat(vec(10), 6'd9, 5'd4, 1'b1); expect_grp(10, 6'd9, 5'd4, 1'b0);
    beat(vec(7), 6'd10, 5'd6, 1'b0);
    beat(vec(8), 6'd10, 5'd6, 1'b1); expect_grp(15, 6'd10, 5'd6, 1'b0);
    idle(3);

    // exponent mismatch, then a clean group
    beat(vec(3), 6'd12, 5'd8, 1'b0);
    beat(vec(4), 6'd13, 5'd8, 1'b1); expect_grp(7, 6'd12, 5'd8, 1'b1);
    beat(vec(2), 6'd12, 5'd8, 1'b1); expect_grp(2, 6'd12, 5'd8, 1'b0);
    idle(3);

    // reset mid-group discards the open partial group
    beat(vec(50), 6'd30, 5'd11, 1'b0);
    beat(vec(50), 6'd30, 5'd11, 1'b0);
    idle(1);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk);
    chk_zero("midreset_hold");
    rst_n = 1'b1;
    beat(vec(9), 6'd14, 5'd15, 1'b1); expect_grp(9, 6'd14, 5'd15, 1'b0);
    idle(6);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pp_group_accumulator.md
Name: pp_group_accumulator

Overview:
- Downstream neighbour of the partial-product alignment stage in the MAC subsystem.
- Each valid beat carries N_LANES aligned, signed partial products, all aligned to one shared max exponent. The block reduces them through a 2-stage pipelined adder tree.
- Beats are grouped: consecutive vector sums are accumulated until a beat flagged last. The group total is then emitted with its max exponent and Q fraction for the normalisation stage.

Parameters:
- N_LANES, 8, aligned partial products per beat; power of two, 2..16.
- PP_W, 15, width of each aligned partial product (two's complement).
- GRP_W, 4, log2 of maximum beats per group (16).
- ACC_W, PP_W+log2(N_LANES)+GRP_W (22), accumulator and output width.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  beat valid.
- i_pp  input  N_LANES*PP_W  packed partial products; lane k at bits [k*PP_W +: PP_W].
- i_max_exp  input  6  shared max exponent of the beat.
- i_Q_frac  input  5  Q fraction tag of the beat.
- i_last  input  1  beat closes the current group; qualified by i_valid.
- o_valid  output  1  group result valid, one-cycle pulse.
- o_sum  output  ACC_W  signed group total.
- o_max_exp  output  6  max exponent of the group.
- o_Q_frac  output  5  Q fraction of the group.
- o_exp_err  output  1  some beat in the group had a max_exp differing from the group's first beat.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - All pipeline registers, the accumulator and the group-open flag clear to 0.
  - o_valid=0, o_sum=0, o_max_exp=0, o_Q_frac=0, o_exp_err=0.
  - Reset mid-group discards the partial group. The first valid beat after release starts a new group.
- Stage 1 (register on i_clk):
  - Each lane is sign-extended to ACC_W. Adjacent lane pairs are added, giving N_LANES/2 partial sums.
  - i_valid, i_last, i_max_exp and i_Q_frac are registered alongside.
- Stage 2 (register on i_clk):
  - The remaining tree reduces the partial sums to the vector sum vs.
  - If the stage-1 valid is high:
    - Group not open: acc <= vs; grp_exp <= stage-1 max_exp; grp_q <= stage-1 Q_frac; err <= 0.
    - Group open: acc <= acc + vs; err <= err | (stage-1 max_exp != grp_exp). grp_exp and grp_q stay unchanged.
    - Group-open flag <= ~stage-1 last.
  - A beat that is both first and last forms a one-beat group.
- Output:
  - o_valid pulses high for exactly one cycle, 2 cycles after the beat with i_valid=1 and i_last=1 is sampled. Equivalently, it is registered in stage 2 from stage-1 valid & last.
  - o_sum, o_max_exp, o_Q_frac and o_exp_err present the completed group, including the contribution of the last beat, in the same cycle as o_valid.
  - They hold their value until the next group completes.
- Throughput and flow:
  - One beat per cycle, no backpressure.
  - Gaps (i_valid=0) inside a group are allowed and leave acc unchanged.
  - i_last and all data with i_valid=0 are ignored.
- Arithmetic:
  - All sums are two's complement. ACC_W is sized so groups of up to 2^GRP_W beats cannot overflow.
  - Longer groups are not supported; the accumulator wraps modulo 2^ACC_W with no flag.
- Group boundaries:
  - A new group's first beat may arrive the cycle right after a last beat.
  - The new group's first beat overwrites acc; no stale sum may leak into it.
  - o_valid for the old group and the first accumulate of the new group occur in consecutive cycles without conflict.
- o_exp_err is informational only and does not alter o_sum.

Test Plan:
- Single one-beat group, N_LANES=8:
  - Stimulus: lanes = 1,2,3,4,5,6,7,8; max_exp=6'd20; Q_frac=5'd3; i_last=1.
  - Required: o_valid high exactly 2 cycles later; o_sum=36, o_max_exp=20, o_Q_frac=3, o_exp_err=0.
- Negative lanes:
  - Stimulus: all lanes = 15'h7FFF (-1), one-beat group.
  - Required: o_sum=-8 (22'h3FFFF8).
- Three-beat group with gaps:
  - Stimulus: vector sums 100, -40, 5; two idle cycles between beats 1 and 2.
  - Required: a single o_valid, 2 cycles after beat 3, with o_sum=65; no o_valid earlier.
- Back-to-back groups:
  - Stimulus: group A = one beat with sum 10 and last=1, then group B = beat sums 7 and 8 (last on the second) on the following cycles.
  - Required: o_valid pulses with 10, then with 15; B is unaffected by A.
- Exponent mismatch:
  - Stimulus: beat 1 with max_exp=12, beat 2 (last) with max_exp=13.
  - Required: o_exp_err=1 and o_max_exp=12. A following clean group reports o_exp_err=0.
- Reset mid-group:
  - Stimulus: two beats of sum 50 with no last, then pulse i_rst_n low asynchronously, then a one-beat group with sum 9.
  - Required: all outputs 0 during reset; after release the result is o_sum=9.
